// File: rtl/ce213_lab4_pkg.sv
// Shared definitions for the Count1 stimulus generator: state codes and default sizing.
package ce213_lab4_pkg;

  localparam int LEN_W_DEF      = 3;
  localparam int GAP_CYCLES_DEF = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ONES = 2'b01,
    S_GAP  = 2'b10
  } genState_t;

  // Counter must hold the longest run and the longest gap (up to 15).
  function automatic int cntWidth(input int lenW);
    return (lenW > 4) ? lenW : 4;
  endfunction

endpackage

// File: rtl/gen_down_counter.sv
// Loadable decrement-by-1 counter; shared between the ONES and GAP phases of the generator.
module gen_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] count,
  output logic             isOne
);

  logic [WIDTH-1:0] countReg;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= loadValue;
    end else if (dec && (countReg != '0)) begin
      countReg <= countReg - WIDTH'(1);
    end
  end

  assign count = countReg;
  assign isOne = (countReg == WIDTH'(1));

endmodule

// File: rtl/ones_run_generator.sv
// Emits RunLen consecutive 1s on W, then GAP_CYCLES 0s with Done in the last gap cycle.
module ones_run_generator
  import ce213_lab4_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [LEN_W-1:0] RunLen,
  output logic             Ready,
  output logic             W,
  output logic             Done,
  output logic             Busy
);

  localparam int CNT_W = cntWidth(LEN_W);

  genState_t        stateReg;
  genState_t        stateNext;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] loadVal;
  logic             loadEn;
  logic             decEn;
  logic             isOne;
  logic             nextIsOne;
  logic             wReg;
  logic             doneReg;

  gen_down_counter #(
    .WIDTH(CNT_W)
  ) uCounter (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .load     (loadEn),
    .dec      (decEn),
    .loadValue(loadVal),
    .count    (count),
    .isOne    (isOne)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stateReg <= S_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    loadEn    = 1'b0;
    decEn     = 1'b0;
    loadVal   = '0;
    case (stateReg)
      S_IDLE: begin
        if (Start) begin
          loadEn = 1'b1;
          if (RunLen != '0) begin
            stateNext = S_ONES;
            loadVal   = CNT_W'(RunLen);
          end else begin
            stateNext = S_GAP;
            loadVal   = CNT_W'(GAP_CYCLES);
          end
        end
      end
      S_ONES: begin
        if (isOne) begin
          stateNext = S_GAP;
          loadEn    = 1'b1;
          loadVal   = CNT_W'(GAP_CYCLES);
        end else begin
          decEn = 1'b1;
        end
      end
      S_GAP: begin
        decEn = 1'b1;
        if (isOne) begin
          stateNext = S_IDLE;
        end
      end
      default: begin
        stateNext = S_IDLE;
        loadEn    = 1'b1;
      end
    endcase
  end

  // Look ahead at the counter so Done lands in the final gap cycle from a register.
  always_comb begin
    nextIsOne = 1'b0;
    if (loadEn) begin
      nextIsOne = (loadVal == CNT_W'(1));
    end else if (decEn) begin
      nextIsOne = (count == CNT_W'(2));
    end else begin
      nextIsOne = isOne;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wReg    <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      wReg    <= (stateNext == S_ONES);
      doneReg <= (stateNext == S_GAP) && nextIsOne;
    end
  end

  assign Ready = (stateReg == S_IDLE);
  assign Busy  = ~Ready;
  assign W     = wReg;
  assign Done  = doneReg;

endmodule

// File: tb/tb_ones_run_generator.sv
// Directed bench for ones_run_generator with a behavioural Count1 counter on W.
module tb_ones_run_generator;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start;
  logic [2:0] RunLen;
  logic       Ready;
  logic       W;
  logic       Done;
  logic       Busy;

  int checks   = 0;
  int failures = 0;
  int cnt1;

  ones_run_generator #(
    .LEN_W     (3),
    .GAP_CYCLES(1)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Start (Start),
    .RunLen(RunLen),
    .Ready (Ready),
    .W     (W),
    .Done  (Done),
    .Busy  (Busy)
  );

  always #5 Clock = ~Clock;

  // Consecutive-ones counter that W drives, saturating at 4 (state 100).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) cnt1 <= 0;
    else if (W) cnt1 <= (cnt1 >= 4) ? 4 : cnt1 + 1;
    else cnt1 <= 0;
  end

  task automatic checkEq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the accept cycle; expW/expD bit c-1 holds the value expected in cycle c.
  task automatic runCase(input string tag, input int len, input int len2, input int hold,
                         input int n, input logic [15:0] expW, input logic [15:0] expD,
                         input int gapCycle, input int expCnt);
    Start  = 1'b1;
    RunLen = 3'(len);
    for (int c = 1; c <= n; c++) begin
      if (c == 2) RunLen = 3'(len2);
      if (c == hold + 1) Start = 1'b0;
      checkEq($sformatf("%s W c%0d", tag, c), int'(W), int'(expW[c-1]));
      checkEq($sformatf("%s Done c%0d", tag, c), int'(Done), int'(expD[c-1]));
      if (c == gapCycle) checkEq($sformatf("%s cnt1 c%0d", tag, c), cnt1, expCnt);
      @(negedge Clock);
    end
    Start = 1'b0;
    checkEq($sformatf("%s cnt1 after gap", tag), cnt1, 0);
    checkEq($sformatf("%s Ready end", tag), int'(Ready), 1);
    $display("run %s len=%0d cycles=%0d checks=%0d failures=%0d", tag, len, n, checks, failures);
  endtask

  initial begin
    Resetn = 1'b0;
    Start  = 1'b1;
    RunLen = 3'd4;
    #1;
    checkEq("rst W", int'(W), 0);
    checkEq("rst Done", int'(Done), 0);
    checkEq("rst Ready", int'(Ready), 1);
    checkEq("rst Busy", int'(Busy), 0);
    repeat (3) @(negedge Clock);
    checkEq("rst hold W", int'(W), 0);
    checkEq("rst hold Ready", int'(Ready), 1);
    Start  = 1'b0;
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    checkEq("post rst W", int'(W), 0);
    checkEq("post rst Ready", int'(Ready), 1);
    $display("reset checks=%0d failures=%0d", checks, failures);

    // RunLen=4: W 0,1,1,1,1,0 and Done in cycle 6; counter reaches 4.
    runCase("len4", 4, 4, 1, 6, 16'h001E, 16'h0020, 6, 4);
    // RunLen=0: no ones, Done two cycles into the request.
    runCase("len0", 0, 0, 1, 3, 16'h0000, 16'h0002, 2, 0);
    // Start held, RunLen=7 then changed to 2: 7 ones, gap+Done, idle, 2 ones, gap+Done.
    runCase("b2b", 7, 2, 12, 14, 16'h0CFE, 16'h1100, 9, 4);

    for (int len = 0; len <= 7; len++) begin
      runCase($sformatf("sweep%0d", len), len, len, 1, len + 3,
              16'(((1 << len) - 1) << 1), 16'(1 << (len + 1)), len + 2, (len > 4) ? 4 : len);
    end

    // Reset during the third one of a RunLen=5 run.
    Start  = 1'b1;
    RunLen = 3'd5;
    @(negedge Clock);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    checkEq("midrst W before", int'(W), 1);
    #2 Resetn = 1'b0;
    #1;
    checkEq("midrst W async", int'(W), 0);
    checkEq("midrst Ready async", int'(Ready), 1);
    checkEq("midrst Done async", int'(Done), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checkEq($sformatf("midrst Done c%0d", c), int'(Done), 0);
      checkEq($sformatf("midrst W c%0d", c), int'(W), 0);
      @(negedge Clock);
    end
    checkEq("midrst Ready", int'(Ready), 1);
    $display("midrst checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
